// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage program counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_gen_unit_ras.sv
// Circular return-address stack: push writes at ptr, pop reads below ptr.
// A push on a full stack silently overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);
  import pc_gen_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

  // Simultaneous pop+push replaces the top entry in place.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (pop_i && push_i) begin
      ptr_d = ptr_q;
    end else if (pop_i) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_i) begin
      ptr_d = ptr_inc;
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[pop_i ? ptr_dec : ptr_q] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_dec];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage next-PC generator: seq/branch/jalr/trap selection, halt/resume, misalign trap.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h100),
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  input  logic [1:0]       pc_sel,
  input  logic             redirect,
  input  logic [WIDTH-1:0] pc_base,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             trap_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] target, jalr_sum, ras_top;
  logic             misaligned, advance, ras_pop;

  assign pc_plus  = pc_q + STEP;
  assign jalr_sum = rs1 + ImmOp;

  always_comb begin
    target = pc_plus;
    unique case (pc_sel_e'(pc_sel))
      PC_BRANCH: target = pc_base + ImmOp;
      PC_JALR:   target = {jalr_sum[WIDTH-1:1], 1'b0};
      PC_SEQ,
      PC_RSVD:   target = pc_plus;
    endcase
  end

  assign misaligned = |(target & ALIGN_MASK);

`ifdef PC_RAS_EN
  logic ras_empty;

  // A return only pops when nothing of higher priority redirects this cycle.
  assign ras_pop = ret_i && !trap_i && !redirect && !ras_empty;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (call_i),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  logic unused_ras;

  assign ras_pop    = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = call_i ^ ret_i ^ (RAS_DEPTH == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_i && !trap_i && !redirect) state_d = ST_HALT;
      ST_HALT: if (trap_i || resume_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  assign advance = (state_q == ST_RUN) && pc_valid && fetch_ready;

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (trap_i) begin
      pc_d = TRAP_VECTOR;
    end else if (redirect) begin
      pc_d  = misaligned ? TRAP_VECTOR : target;
      mis_d = misaligned;
    end else if (ras_pop) begin
      pc_d = ras_top;
    end else if (halt_i) begin
      pc_d = pc_q;
    end else if (advance) begin
      pc_d = pc_plus;
    end
  end

  always_comb begin
    pc_valid   = (state_q == ST_RUN);
    pc         = pc_q;
    misalign_o = mis_q;
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: expected pc/valid/misalign per cycle are queued
// with the stimulus and compared one cycle later. Covers PC_RAS_EN when defined.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, pc_valid, redirect;
  logic        trap_i, halt_i, resume_i, call_i, ret_i, misalign_o;
  logic [1:0]  pc_sel;
  logic [31:0] pc, pc_plus, pc_base, rs1, ImmOp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  pc_gen_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_ready (fetch_ready),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .pc_sel      (pc_sel),
    .redirect    (redirect),
    .pc_base     (pc_base),
    .rs1         (rs1),
    .ImmOp       (ImmOp),
    .trap_i      (trap_i),
    .halt_i      (halt_i),
    .resume_i    (resume_i),
    .call_i      (call_i),
    .ret_i       (ret_i),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] p, input logic m);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = p; e.mis = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_valid"}, {31'd0, pc_valid}, {31'd0, e.valid});
      check({e.tag, "_pc"}, pc, e.pc);
      check({e.tag, "_plus"}, pc_plus, e.pc + 32'd4);
      check({e.tag, "_mis"}, {31'd0, misalign_o}, {31'd0, e.mis});
    end
  endtask

  task automatic clr();
    redirect = 1'b0; trap_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
    call_i = 1'b0; ret_i = 1'b0; pc_sel = 2'b00;
    pc_base = '0; rs1 = '0; ImmOp = '0;
  endtask

  task automatic br(input logic [31:0] base, input logic [31:0] imm);
    redirect = 1'b1; pc_sel = 2'b01; pc_base = base; ImmOp = imm;
  endtask

  task automatic jalr(input logic [31:0] r, input logic [31:0] imm);
    redirect = 1'b1; pc_sel = 2'b10; rs1 = r; ImmOp = imm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    rst = 1'b1; fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    step("boot_exit", 1'b1, 32'h0, 1'b0);
    step("seq4", 1'b1, 32'h4, 1'b0);
    step("seq8", 1'b1, 32'h8, 1'b0);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h8, 1'b0);
    fetch_ready = 1'b1;
    step("unstall", 1'b1, 32'hC, 1'b0);
    step("seq10", 1'b1, 32'h10, 1'b0);

    fetch_ready = 1'b0; br(32'h10, -32'sd8);
    step("branch_back", 1'b1, 32'h8, 1'b0);
    clr(); fetch_ready = 1'b1;
    step("after_branch", 1'b1, 32'hC, 1'b0);
    fetch_ready = 1'b0; redirect = 1'b1; pc_sel = 2'b11;
    step("rsvd_seq", 1'b1, 32'h10, 1'b0);
    clr(); fetch_ready = 1'b1;

    jalr(32'h203, 32'h0);
    step("jalr_mis", 1'b1, 32'h100, 1'b1);
    clr();
    step("mis_clear", 1'b1, 32'h104, 1'b0);
    jalr(32'h201, 32'h0);
    step("jalr_bit0", 1'b1, 32'h200, 1'b0);
    br(32'h200, 32'h2);
    step("br_mis", 1'b1, 32'h100, 1'b1);
    br(32'h0, 32'h20);
    step("to_20", 1'b1, 32'h20, 1'b0);

    clr(); halt_i = 1'b1;
    step("halt", 1'b0, 32'h20, 1'b0);
    halt_i = 1'b0;
    for (int i = 0; i < 2; i++) step("halt_hold", 1'b0, 32'h20, 1'b0);
    resume_i = 1'b1;
    step("resume", 1'b1, 32'h20, 1'b0);
    resume_i = 1'b0;
    step("after_resume", 1'b1, 32'h24, 1'b0);

    trap_i = 1'b1; br(32'h0, 32'h40);
    step("trap_prio", 1'b1, 32'h100, 1'b0);
    clr();
    step("after_trap", 1'b1, 32'h104, 1'b0);
    halt_i = 1'b1;
    step("halt2", 1'b0, 32'h104, 1'b0);
    halt_i = 1'b0; trap_i = 1'b1;
    step("trap_in_halt", 1'b1, 32'h100, 1'b0);
    clr();
    step("after_trap2", 1'b1, 32'h104, 1'b0);
    halt_i = 1'b1; br(32'h300, 32'h0);
    step("redir_over_halt", 1'b1, 32'h300, 1'b0);
    clr();
    step("after_redir", 1'b1, 32'h304, 1'b0);

    rst = 1'b1; br(32'h500, 32'h0);
    step("rst_mid", 1'b0, 32'h0, 1'b0);
    rst = 1'b0; br(32'h400, 32'h0);
    step("boot_redir", 1'b1, 32'h400, 1'b0);
    clr();
    step("after_boot", 1'b1, 32'h404, 1'b0);

    br(32'hFFFF_FFFC, 32'h0);
    step("top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    clr();
    step("wrap", 1'b1, 32'h0, 1'b0);

    br(32'h0, 32'h40);
    step("to_40", 1'b1, 32'h40, 1'b0);
    clr();
`ifdef PC_RAS_EN
    call_i = 1'b1; br(32'h40, 32'h40);
    step("call1", 1'b1, 32'h80, 1'b0);
    br(32'h80, 32'h100);
    step("call2", 1'b1, 32'h180, 1'b0);
    clr(); ret_i = 1'b1;
    step("ret1", 1'b1, 32'h84, 1'b0);
    step("ret2", 1'b1, 32'h44, 1'b0);
    step("ret_empty", 1'b1, 32'h48, 1'b0);
    clr();
    step("after_ret", 1'b1, 32'h4C, 1'b0);
`else
    call_i = 1'b1; ret_i = 1'b1;
    step("callret_ign", 1'b1, 32'h44, 1'b0);
    call_i = 1'b0;
    step("ret_ign", 1'b1, 32'h48, 1'b0);
    clr();
    step("after_ret", 1'b1, 32'h4C, 1'b0);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
